// File: rtl/spi_endpoint_arbiter_if.sv
// Bus bundle between the SPI stack, the endpoint arbiter and its endpoints.
// Signals: spi_req_*  (SPI send side -> arbiter), port_req_* (arbiter -> endpoints),
//          port_resp_* (endpoints -> arbiter), spi_resp_* (arbiter -> SPI recv side).
// Modports: slave = arbiter view, master = surrounding environment view.
interface spi_endpoint_arbiter_if #(
  parameter int nbits     = 32,
  parameter int num_ports = 4
);
  logic                           spi_req_val;
  logic [nbits-1:0]               spi_req_msg;
  logic                           spi_req_rdy;
  logic [num_ports-1:0]           port_req_val;
  logic [nbits-3:0]               port_req_msg;
  logic [num_ports-1:0]           port_req_rdy;
  logic [num_ports-1:0]           port_resp_val;
  logic [num_ports*(nbits-2)-1:0] port_resp_msg;
  logic [num_ports-1:0]           port_resp_rdy;
  logic                           spi_resp_val;
  logic [nbits-1:0]               spi_resp_msg;
  logic                           spi_resp_rdy;

  modport slave (
    input  spi_req_val, spi_req_msg, port_req_rdy, port_resp_val, port_resp_msg, spi_resp_rdy,
    output spi_req_rdy, port_req_val, port_req_msg, port_resp_rdy, spi_resp_val, spi_resp_msg
  );

  modport master (
    output spi_req_val, spi_req_msg, port_req_rdy, port_resp_val, port_resp_msg, spi_resp_rdy,
    input  spi_req_rdy, port_req_val, port_req_msg, port_resp_rdy, spi_resp_val, spi_resp_msg
  );
endinterface

// File: rtl/spi_endpoint_arbiter.sv
// spi_endpoint_arbiter: routes SPI request packets to one of up to four endpoints
// by the top two message bits (zero latency) and merges endpoint responses into a
// single registered output slot, granted round-robin and tagged with the source id.
// Ports: clk, reset (synchronous, active-high), bus (spi_endpoint_arbiter_if.slave).
// Option macro SPI_ARB_ERR_RESP_EN: an invalid-id request is answered with
// {id, all ones}; without it such requests are accepted and dropped.
module spi_endpoint_arbiter #(
  parameter int nbits     = 32,
  parameter int num_ports = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_endpoint_arbiter_if.slave bus
);
  localparam int pw = nbits - 2;

  logic [1:0]       req_id;
  logic             load_en;
  logic             grant_vld;
  logic [1:0]       grant;
  logic [pw-1:0]    grant_msg;
  logic             take_port;
  logic             err_load;
  logic [nbits-1:0] err_msg;
  logic             out_full;
  logic [nbits-1:0] out_msg;
  logic [1:0]       ptr;

  assign req_id           = bus.spi_req_msg[nbits-1 -: 2];
  assign bus.port_req_msg = bus.spi_req_msg[pw-1:0];
  assign bus.spi_resp_val = out_full;
  assign bus.spi_resp_msg = out_msg;
  assign load_en          = !out_full || bus.spi_resp_rdy;

`ifdef SPI_ARB_ERR_RESP_EN
  logic       err_pend;
  logic [1:0] err_id;
  logic       req_bad;

  assign req_bad  = bus.spi_req_val && (32'(req_id) >= 32'(num_ports));
  assign err_load = err_pend && load_en && !reset;
  assign err_msg  = {err_id, {pw{1'b1}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      err_pend <= 1'b0;
      err_id   <= '0;
    end else if (err_load) begin
      err_pend <= 1'b0;
    end else if (req_bad && !err_pend) begin
      err_pend <= 1'b1;
      err_id   <= req_id;
    end
  end
`else
  assign err_load = 1'b0;
  assign err_msg  = '0;
`endif

  // Request decode: an id with no matching port falls through to the default ready.
  always_comb begin
    bus.port_req_val = '0;
`ifdef SPI_ARB_ERR_RESP_EN
    bus.spi_req_rdy  = !err_pend;
`else
    bus.spi_req_rdy  = 1'b1;
`endif
    for (int unsigned i = 0; i < num_ports; i++) begin
      if (req_id == 2'(i)) begin
        bus.port_req_val[i] = bus.spi_req_val;
        bus.spi_req_rdy     = bus.port_req_rdy[i];
      end
    end
  end

  // Round-robin scan from ptr+1 done as two priority passes: ports above ptr first,
  // then wrap to ports at or below ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int unsigned i = 0; i < num_ports; i++) begin
      if (!grant_vld && bus.port_resp_val[i] && (2'(i) > ptr)) begin
        grant_vld = 1'b1;
        grant     = 2'(i);
      end
    end
    for (int unsigned i = 0; i < num_ports; i++) begin
      if (!grant_vld && bus.port_resp_val[i] && (2'(i) <= ptr)) begin
        grant_vld = 1'b1;
        grant     = 2'(i);
      end
    end
  end

  assign take_port = grant_vld && load_en && !err_load && !reset;

  always_comb begin
    bus.port_resp_rdy = '0;
    grant_msg         = '0;
    for (int unsigned i = 0; i < num_ports; i++) begin
      if (grant == 2'(i)) begin
        bus.port_resp_rdy[i] = take_port;
        grant_msg            = bus.port_resp_msg[i*pw +: pw];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_full <= 1'b0;
      out_msg  <= '0;
      ptr      <= 2'(num_ports - 1);
    end else if (err_load) begin
      out_full <= 1'b1;
      out_msg  <= err_msg;
    end else if (take_port) begin
      out_full <= 1'b1;
      out_msg  <= {grant, grant_msg};
      ptr      <= grant;
    end else if (out_full && bus.spi_resp_rdy) begin
      out_full <= 1'b0;
    end
  end
endmodule
